// File: rtl/param_regfile_alu_pkg.sv
// Shared constants for the register-file ALU: opcodes, FSM encoding and the
// hex-to-segment table used by the display scanner.
package param_regfile_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // Segment order is g..a, active-low.
    function automatic logic [6:0] hex_to_a2g(input logic [3:0] h);
        logic [6:0] seg;
        seg = 7'h7F;
        case (h)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/param_regfile_alu_seg7_scan.sv
// Multiplexed 7-segment scanner: digits 0..D-1 show Q1, digits 4..4+D-1 show Q2,
// remaining slots are blanked so the scan period is independent of WIDTH.
module seg7_scan
    import param_regfile_alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SCAN_BITS = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] q1_i,
    input  logic [WIDTH-1:0] q2_i,
    input  logic             zero_i,
    output logic [7:0]       an_o,
    output logic [6:0]       a2g_o,
    output logic             dp_o
);

    localparam int D = WIDTH / 4;

    logic [SCAN_BITS-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]           digit;
    logic [1:0]           slot;
    logic [15:0]          q1_ext, q2_ext;
    logic [3:0]           nibble;
    logic                 active;

    assign scan_cnt_d = scan_cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) scan_cnt_q <= '0;
        else       scan_cnt_q <= scan_cnt_d;
    end

    assign q1_ext = 16'(q1_i);
    assign q2_ext = 16'(q2_i);
    assign digit  = scan_cnt_q[SCAN_BITS-1 -: 3];
    assign slot   = digit[1:0];
    assign active = (int'(slot) < D);

    always_comb begin
        an_o   = 8'hFF;
        a2g_o  = 7'h7F;
        dp_o   = 1'b1;
        nibble = digit[2] ? q2_ext[{slot, 2'b00} +: 4] : q1_ext[{slot, 2'b00} +: 4];
        if (active) begin
            an_o[digit] = 1'b0;
            a2g_o       = hex_to_a2g(nibble);
            dp_o        = ~((digit == 3'd0) && zero_i);
        end
    end

endmodule

// File: rtl/param_regfile_alu.sv
// Register-file ALU: one READ/EXEC/WRITE pass per step tick, optional
// write-back to mem[N1], zero/carry flags, operands scanned on the display.
module param_regfile_alu
    import param_regfile_alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int INIT_VAL  = 1,
    parameter int STEP_DIV  = 8388608,
    parameter int SCAN_BITS = 20
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] N1,
    input  logic [$clog2(DEPTH)-1:0] N2,
    input  logic [2:0]               op,
    input  logic                     WE,
    output logic                     busy,
    output logic                     zero,
    output logic                     carry,
    output logic                     DP,
    output logic [7:0]               AN,
    output logic [6:0]               A2G,
    output logic [1:0]               state_dbg_o
);

    localparam int SW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW  = WIDTH / 2;
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SW-1:0]    step_cnt_q;
    logic             step_tick;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q1_q, q2_q, result_q;
    logic [2:0]       op_q;
    logic             zero_q, carry_q;

    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_res, mul_a, mul_b;
    logic             alu_carry;

    assign step_tick = (step_cnt_q == SW'(STEP_DIV - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (reset || step_tick) step_cnt_q <= '0;
        else                    step_cnt_q <= step_cnt_q + 1'b1;
    end

    // Ticks arriving outside IDLE are dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (step_tick) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WRITE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(INIT_VAL);
        end else if (state_q == ST_WRITE && WE) begin
            mem_q[N1] <= result_q;
        end
    end

    // Multiply uses only the low halves so the product always fits in WIDTH.
    assign mul_a = WIDTH'(q1_q[HW-1:0]);
    assign mul_b = WIDTH'(q2_q[HW-1:0]);

    always_comb begin
        alu_sum   = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_sum   = {1'b0, q1_q} + {1'b0, q2_q};
                alu_res   = alu_sum[WIDTH-1:0];
                alu_carry = alu_sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = q1_q - q2_q;
                alu_carry = (q1_q < q2_q);
            end
            OP_NOT:  alu_res = ~q1_q;
            OP_MUL:  alu_res = mul_a * mul_b;
            OP_AND:  alu_res = q1_q & q2_q;
            OP_OR:   alu_res = q1_q | q2_q;
            OP_XOR:  alu_res = q1_q ^ q2_q;
            default: alu_res = q1_q << q2_q[SHW-1:0];
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            q1_q     <= WIDTH'(INIT_VAL);
            q2_q     <= WIDTH'(INIT_VAL);
            op_q     <= OP_ADD;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            if (state_q == ST_READ) begin
                q1_q <= mem_q[N1];
                q2_q <= mem_q[N2];
                op_q <= op;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                carry_q  <= alu_carry;
            end
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign state_dbg_o = state_q;

    seg7_scan #(
        .WIDTH     (WIDTH),
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .clk_i  (CLK100MHZ),
        .rst_i  (reset),
        .q1_i   (q1_q),
        .q2_i   (q2_q),
        .zero_i (zero_q),
        .an_o   (AN),
        .a2g_o  (A2G),
        .dp_o   (DP)
    );

endmodule
